// File: rtl/alu_nzcv_pipe.sv
// Two-stage ALU: S1 registers operands/op, S2 executes into the output register and
// updates the architectural NZCV register. Valid/ready on both sides, capacity 2 under stall.
module alu_nzcv_pipe #(
    parameter int WIDTH = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_res,
    output logic [3:0]       out_nzcv,
    output logic [3:0]       flags
);
    localparam int MSB = WIDTH - 1;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [2:0]       op;
    } req_t;

    logic             s1_valid_q;
    req_t             s1_q;
    logic             out_valid_q;
    logic [WIDTH-1:0] res_q;
    logic [3:0]       nzcv_q;
    logic [3:0]       flags_q;

    logic             adv;
    logic [WIDTH-1:0] res_d;
    logic [3:0]       nzcv_d;
    logic             c_d;
    logic             v_d;
    logic [WIDTH-1:0] bx;
    logic             cin;
    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   shamt;
    logic [WIDTH:0]   shext;

    assign adv      = !out_valid_q || out_ready;
    assign in_ready = !s1_valid_q || adv;

    // op[1] selects subtract (invert B), op[0] takes carry-in from the stored C flag
    always_comb begin
        res_d = '0;
        c_d   = 1'b0;
        v_d   = 1'b0;
        bx    = s1_q.op[1] ? ~s1_q.b : s1_q.b;
        cin   = s1_q.op[0] ? flags_q[1] : s1_q.op[1];
        sum   = {1'b0, s1_q.a} + {1'b0, bx} + {{WIDTH{1'b0}}, cin};
        shamt = s1_q.b[SHW-1:0];
        shext = {1'b0, s1_q.a} << shamt;
        case (s1_q.op)
            3'b000, 3'b001, 3'b010, 3'b011: begin
                res_d = sum[WIDTH-1:0];
                c_d   = sum[WIDTH];
                if (s1_q.op[1])
                    v_d = (s1_q.a[MSB] != s1_q.b[MSB]) && (res_d[MSB] != s1_q.a[MSB]);
                else
                    v_d = (s1_q.a[MSB] == s1_q.b[MSB]) && (res_d[MSB] != s1_q.a[MSB]);
            end
            3'b100: res_d = s1_q.a & s1_q.b;
            3'b101: res_d = s1_q.a | s1_q.b;
            3'b110: res_d = s1_q.a ^ s1_q.b;
            default: begin
                // extra top bit of the shifted value is the last bit shifted out
                if ({1'b0, shamt} < (SHW+1)'(WIDTH)) begin
                    res_d = shext[WIDTH-1:0];
                    c_d   = shext[WIDTH];
                end
            end
        endcase
        nzcv_d = {res_d[MSB], res_d == '0, c_d, v_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_q        <= '0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            nzcv_q      <= '0;
            flags_q     <= '0;
        end else begin
            if (in_ready) begin
                s1_valid_q <= in_valid;
                if (in_valid) s1_q <= '{a: in_a, b: in_b, op: in_op};
            end
            if (adv) begin
                out_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    res_q   <= res_d;
                    nzcv_q  <= nzcv_d;
                    flags_q <= nzcv_d;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_res   = res_q;
    assign out_nzcv  = nzcv_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_alu_nzcv_pipe.sv
// Scoreboard bench for alu_nzcv_pipe (WIDTH=4): driver pushes hand-computed results,
// a negedge monitor pops and compares on every output transfer.
module tb_alu_nzcv_pipe;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [2:0] in_op;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_res;
    logic [3:0] out_nzcv;
    logic [3:0] flags;

    int n_cmp = 0;
    int n_bad = 0;
    int last_wait;
    logic [7:0] exp_q[$];

    localparam logic [2:0] ADD = 3'b000, ADC = 3'b001, SUB = 3'b010, SBC = 3'b011,
                           AND = 3'b100, OR  = 3'b101, XOR = 3'b110, SLL = 3'b111;

    always #5 clk = ~clk;

    alu_nzcv_pipe #(.WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
        .out_ready(out_ready), .out_res(out_res), .out_nzcv(out_nzcv), .flags(flags)
    );

    task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] er, input logic [3:0] en, input bit push);
        int w;
        w = 0;
        in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL accept_timeout: in_ready still 0 after %0d cycles", w);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        if (push) exp_q.push_back({er, en});
        #1 in_valid = 1'b0;
        last_wait = w;
    endtask

    // monitor: a transfer seen at negedge completes on the following posedge
    initial begin
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {out_res, out_nzcv}, 8'hxx);
                end else begin
                    e = exp_q.pop_front();
                    check("res",   {4'h0, out_res},  {4'h0, e[7:4]});
                    check("nzcv",  {4'h0, out_nzcv}, {4'h0, e[3:0]});
                    check("flags", {4'h0, flags},    {4'h0, e[3:0]});
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; out_ready = 1'b1;
        last_wait = 0;
        #12;
        check("rst_out_valid", {7'h0, out_valid}, 8'h00);
        check("rst_res_nzcv",  {out_res, out_nzcv}, 8'h00);
        check("rst_flags",     {4'h0, flags}, 8'h00);
        check("rst_in_ready",  {7'h0, in_ready}, 8'h01);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // latency: accepted at edge k, visible after edge k+1
        send(4'h7, 4'h1, ADD, 4'h8, 4'b1001, 1'b1);
        @(negedge clk);
        check("latency_k", {7'h0, out_valid}, 8'h00);
        @(negedge clk);
        check("latency_k1", {7'h0, out_valid}, 8'h01);
        @(posedge clk); #1;

        send(4'h3, 4'h3, SUB, 4'h0, 4'b0110, 1'b1);
        send(4'h2, 4'h5, SUB, 4'hD, 4'b1000, 1'b1);
        send(4'h8, 4'h1, SUB, 4'h7, 4'b0011, 1'b1);

        // carry chain back-to-back, no stalls expected
        send(4'hF, 4'h1, ADD, 4'h0, 4'b0110, 1'b1);
        send(4'h0, 4'h0, ADC, 4'h1, 4'b0000, 1'b1);
        check("chain_no_stall", last_wait[7:0], 8'h00);
        send(4'h5, 4'h2, SBC, 4'h2, 4'b0010, 1'b1);
        check("chain_no_stall2", last_wait[7:0], 8'h00);

        send(4'h9, 4'h1, SLL, 4'h2, 4'b0010, 1'b1);
        send(4'h9, 4'h0, SLL, 4'h9, 4'b1000, 1'b1);
        send(4'h3, 4'h7, SLL, 4'h8, 4'b1010, 1'b1);
        send(4'hC, 4'hA, AND, 4'h8, 4'b1000, 1'b1);
        send(4'h0, 4'h0, OR,  4'h0, 4'b0100, 1'b1);
        send(4'h5, 4'hA, XOR, 4'hF, 4'b1000, 1'b1);
        send(4'h6, 4'h6, XOR, 4'h0, 4'b0100, 1'b1);
        send(4'h9, 4'h9, ADC, 4'h2, 4'b0011, 1'b1);
        repeat (4) @(posedge clk);
        #1;

        // backpressure: two ops fill the pipe, the third must wait
        out_ready = 1'b0;
        fork
            begin
                send(4'hF, 4'h2, ADD, 4'h1, 4'b0010, 1'b1);
                send(4'h1, 4'h1, ADC, 4'h3, 4'b0000, 1'b1);
                send(4'h4, 4'h1, SBC, 4'h2, 4'b0010, 1'b1);
            end
            begin
                repeat (6) @(negedge clk);
                check("stall_in_ready",  {7'h0, in_ready}, 8'h00);
                check("stall_out_valid", {7'h0, out_valid}, 8'h01);
                check("stall_hold",      {out_res, out_nzcv}, 8'h12);
                @(negedge clk);
                check("stall_hold2",     {out_res, out_nzcv}, 8'h12);
                @(posedge clk); #1 out_ready = 1'b1;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        check("drain_empty", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);

        // reset with two ops in flight: everything dropped
        out_ready = 1'b0;
        send(4'h1, 4'h1, ADD, 4'h2, 4'b0000, 1'b0);
        send(4'h7, 4'h7, ADD, 4'hE, 4'b1001, 1'b0);
        @(posedge clk); #2 rst_n = 1'b0;
        #1;
        check("mid_rst_out_valid", {7'h0, out_valid}, 8'h00);
        check("mid_rst_flags",     {4'h0, flags}, 8'h00);
        check("mid_rst_res",       {out_res, out_nzcv}, 8'h00);
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {7'h0, out_valid}, 8'h00);
        @(posedge clk); #1;
        send(4'h0, 4'h0, ADC, 4'h0, 4'b0100, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("final_empty", exp_q.size() == 0 ? 8'h01 : 8'h00, 8'h01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end
endmodule
